// File: rtl/atm_session_driver.sv
// ---------------------------------------------------------------------------
// atm_session_driver
// Customer-side initiator for the ATM controller (Cajero). On each START it
// plays one transaction: card insertion, four strobed PIN digits, then the
// amount with a strobe. It then classifies the controller's answer into
// RESULT.
//
// Ports
//   CLK, RESET            clock (rising edge), async active-low reset
//   START                 session request, accepted only in IDLE
//   TRANS_IN, PIN_IN,     transaction type / PIN / amount, latched at START
//   MONTO_IN
//   TARJETA_RECIBIDA      card present, held for the whole session
//   TIPO_TRANS, MONTO     latched transaction type and amount
//   DIGITO, DIGITO_STB    current PIN digit and its one-cycle strobe
//   MONTO_STB             one-cycle amount strobe
//   BALANCE_ACTUALIZADO,  controller responses
//   ENTREGAR_DINERO, FONDOS_INSUFICIENTES, PIN_INCORRECTO, BLOQUEO
//   BUSY, DONE, RESULT    session active, result-valid pulse, outcome code
//
// state  | meaning
// IDLE   | waiting for START
// CARD   | card inserted, CARD_SETUP cycles before first digit
// DIGIT  | one-cycle digit strobe
// GAP    | DIGIT_GAP cycles between digits
// PWAIT  | PIN_WAIT cycles watching for PIN_INCORRECTO / BLOQUEO
// AMOUNT | one-cycle amount strobe
// RWAIT  | waiting for the transaction outcome or timeout
// FINISH | card released, DONE pulse, RESULT valid
// ---------------------------------------------------------------------------
module atm_session_driver #(
   parameter int CARD_SETUP   = 2,
   parameter int DIGIT_GAP    = 3,
   parameter int PIN_WAIT     = 8,
   parameter int RESP_TIMEOUT = 32
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic        START,
   input  logic        TRANS_IN,
   input  logic [15:0] PIN_IN,
   input  logic [31:0] MONTO_IN,
   output logic        TARJETA_RECIBIDA,
   output logic        TIPO_TRANS,
   output logic [3:0]  DIGITO,
   output logic        DIGITO_STB,
   output logic [31:0] MONTO,
   output logic        MONTO_STB,
   input  logic        BALANCE_ACTUALIZADO,
   input  logic        ENTREGAR_DINERO,
   input  logic        FONDOS_INSUFICIENTES,
   input  logic        PIN_INCORRECTO,
   input  logic        BLOQUEO,
   output logic        BUSY,
   output logic        DONE,
   output logic [2:0]  RESULT
);

   localparam int MAX_AB  = (CARD_SETUP > DIGIT_GAP) ? CARD_SETUP : DIGIT_GAP;
   localparam int MAX_CD  = (PIN_WAIT > RESP_TIMEOUT) ? PIN_WAIT : RESP_TIMEOUT;
   localparam int CNT_MAX = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   localparam logic [CNT_W-1:0] LD_CARD = CNT_W'(CARD_SETUP);
   localparam logic [CNT_W-1:0] LD_GAP  = CNT_W'(DIGIT_GAP);
   localparam logic [CNT_W-1:0] LD_PIN  = CNT_W'(PIN_WAIT);
   localparam logic [CNT_W-1:0] LD_RESP = CNT_W'(RESP_TIMEOUT);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   typedef enum logic [2:0] {
      S_IDLE, S_CARD, S_DIGIT, S_GAP, S_PWAIT, S_AMOUNT, S_RWAIT, S_FINISH
   } state_t;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [1:0]        idx_q, idx_d;
   logic [15:0]       pin_q, pin_d;
   logic              tarjeta_q, tarjeta_d;
   logic              tipo_q, tipo_d;
   logic [3:0]        digito_q, digito_d;
   logic              digito_stb_q, digito_stb_d;
   logic [31:0]       monto_q, monto_d;
   logic              monto_stb_q, monto_stb_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic [2:0]        result_q, result_d;

   logic              fin;
   logic [2:0]        fin_code;
   logic              rsp_any, rsp_multi;

   function automatic logic [3:0] pin_nibble(input logic [15:0] pin, input logic [1:0] idx);
      case (idx)
         2'd0:    return pin[15:12];
         2'd1:    return pin[11:8];
         2'd2:    return pin[7:4];
         default: return pin[3:0];
      endcase
   endfunction

   assign rsp_any   = BALANCE_ACTUALIZADO | ENTREGAR_DINERO | FONDOS_INSUFICIENTES;
   assign rsp_multi = (BALANCE_ACTUALIZADO & ENTREGAR_DINERO) |
                      (BALANCE_ACTUALIZADO & FONDOS_INSUFICIENTES) |
                      (ENTREGAR_DINERO & FONDOS_INSUFICIENTES);

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      idx_d        = idx_q;
      pin_d        = pin_q;
      tarjeta_d    = tarjeta_q;
      tipo_d       = tipo_q;
      digito_d     = digito_q;
      digito_stb_d = 1'b0;
      monto_d      = monto_q;
      monto_stb_d  = 1'b0;
      busy_d       = busy_q;
      done_d       = 1'b0;
      result_d     = result_q;
      fin          = 1'b0;
      fin_code     = 3'd0;

      case (state_q)
         S_IDLE: begin
            if (START) begin
               tipo_d    = TRANS_IN;
               pin_d     = PIN_IN;
               monto_d   = MONTO_IN;
               result_d  = 3'd0;
               tarjeta_d = 1'b1;
               busy_d    = 1'b1;
               cnt_d     = LD_CARD;
               state_d   = S_CARD;
            end
         end
         S_CARD: begin
            if (cnt_q == CNT_ONE) begin
               idx_d        = 2'd0;
               digito_d     = pin_nibble(pin_q, 2'd0);
               digito_stb_d = 1'b1;
               state_d      = S_DIGIT;
            end else begin
               cnt_d = cnt_q - CNT_ONE;
            end
         end
         S_DIGIT: begin
            if (BLOQUEO) begin
               fin = 1'b1; fin_code = 3'd5;
            end else if (PIN_INCORRECTO) begin
               fin = 1'b1; fin_code = 3'd4;
            end else if (idx_q == 2'd3) begin
               cnt_d   = LD_PIN;
               state_d = S_PWAIT;
            end else begin
               cnt_d   = LD_GAP;
               state_d = S_GAP;
            end
         end
         S_GAP: begin
            if (BLOQUEO) begin
               fin = 1'b1; fin_code = 3'd5;
            end else if (PIN_INCORRECTO) begin
               fin = 1'b1; fin_code = 3'd4;
            end else if (cnt_q == CNT_ONE) begin
               idx_d        = idx_q + 2'd1;
               digito_d     = pin_nibble(pin_q, idx_q + 2'd1);
               digito_stb_d = 1'b1;
               state_d      = S_DIGIT;
            end else begin
               cnt_d = cnt_q - CNT_ONE;
            end
         end
         S_PWAIT: begin
            if (BLOQUEO) begin
               fin = 1'b1; fin_code = 3'd5;
            end else if (PIN_INCORRECTO) begin
               fin = 1'b1; fin_code = 3'd4;
            end else if (cnt_q == CNT_ONE) begin
               monto_stb_d = 1'b1;
               cnt_d       = LD_RESP;
               state_d     = S_AMOUNT;
            end else begin
               cnt_d = cnt_q - CNT_ONE;
            end
         end
         // The response timer starts with the strobe cycle itself, so the
         // timeout DONE lands exactly RESP_TIMEOUT cycles after MONTO_STB.
         S_AMOUNT: begin
            if (cnt_q == CNT_ONE) begin
               fin = 1'b1; fin_code = 3'd6;
            end else begin
               cnt_d   = cnt_q - CNT_ONE;
               state_d = S_RWAIT;
            end
         end
         S_RWAIT: begin
            if (BLOQUEO) begin
               fin = 1'b1; fin_code = 3'd5;
            end else if (rsp_any) begin
               fin = 1'b1;
               if (rsp_multi)
                  fin_code = 3'd7;
               else if (!tipo_q)
                  fin_code = BALANCE_ACTUALIZADO ? 3'd1 : 3'd7;
               else if (ENTREGAR_DINERO)
                  fin_code = 3'd2;
               else if (FONDOS_INSUFICIENTES)
                  fin_code = 3'd3;
               else
                  fin_code = 3'd7;
            end else if (cnt_q == CNT_ONE) begin
               fin = 1'b1; fin_code = 3'd6;
            end else begin
               cnt_d = cnt_q - CNT_ONE;
            end
         end
         S_FINISH: begin
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      if (fin) begin
         tarjeta_d = 1'b0;
         done_d    = 1'b1;
         result_d  = fin_code;
         state_d   = S_FINISH;
      end
   end

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state_q      <= S_IDLE;
         cnt_q        <= '0;
         idx_q        <= 2'd0;
         pin_q        <= 16'd0;
         tarjeta_q    <= 1'b0;
         tipo_q       <= 1'b0;
         digito_q     <= 4'd0;
         digito_stb_q <= 1'b0;
         monto_q      <= 32'd0;
         monto_stb_q  <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         result_q     <= 3'd0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         idx_q        <= idx_d;
         pin_q        <= pin_d;
         tarjeta_q    <= tarjeta_d;
         tipo_q       <= tipo_d;
         digito_q     <= digito_d;
         digito_stb_q <= digito_stb_d;
         monto_q      <= monto_d;
         monto_stb_q  <= monto_stb_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         result_q     <= result_d;
      end
   end

   assign TARJETA_RECIBIDA = tarjeta_q;
   assign TIPO_TRANS       = tipo_q;
   assign DIGITO           = digito_q;
   assign DIGITO_STB       = digito_stb_q;
   assign MONTO            = monto_q;
   assign MONTO_STB        = monto_stb_q;
   assign BUSY             = busy_q;
   assign DONE             = done_q;
   assign RESULT           = result_q;

endmodule

// File: tb/tb_atm_session_driver.sv
// ---------------------------------------------------------------------------
// tb_atm_session_driver
// Session-level bench: each session's expected strobes (digit, amount, done)
// are derived from the timing rules and pushed to a scoreboard; a monitor
// pops and compares whenever the DUT presents a strobe.
// ---------------------------------------------------------------------------
module tb_atm_session_driver;

   localparam int CS = 2;
   localparam int DG = 3;
   localparam int PW = 8;
   localparam int RT = 32;

   logic        CLK;
   logic        RESET;
   logic        START;
   logic        TRANS_IN;
   logic [15:0] PIN_IN;
   logic [31:0] MONTO_IN;
   logic        BALANCE_ACTUALIZADO;
   logic        ENTREGAR_DINERO;
   logic        FONDOS_INSUFICIENTES;
   logic        PIN_INCORRECTO;
   logic        BLOQUEO;
   logic        TARJETA_RECIBIDA;
   logic        TIPO_TRANS;
   logic [3:0]  DIGITO;
   logic        DIGITO_STB;
   logic [31:0] MONTO;
   logic        MONTO_STB;
   logic        BUSY;
   logic        DONE;
   logic [2:0]  RESULT;

   atm_session_driver #(
      .CARD_SETUP(CS), .DIGIT_GAP(DG), .PIN_WAIT(PW), .RESP_TIMEOUT(RT)
   ) dut (
      .CLK(CLK), .RESET(RESET), .START(START), .TRANS_IN(TRANS_IN),
      .PIN_IN(PIN_IN), .MONTO_IN(MONTO_IN),
      .TARJETA_RECIBIDA(TARJETA_RECIBIDA), .TIPO_TRANS(TIPO_TRANS),
      .DIGITO(DIGITO), .DIGITO_STB(DIGITO_STB), .MONTO(MONTO),
      .MONTO_STB(MONTO_STB), .BALANCE_ACTUALIZADO(BALANCE_ACTUALIZADO),
      .ENTREGAR_DINERO(ENTREGAR_DINERO),
      .FONDOS_INSUFICIENTES(FONDOS_INSUFICIENTES),
      .PIN_INCORRECTO(PIN_INCORRECTO), .BLOQUEO(BLOQUEO),
      .BUSY(BUSY), .DONE(DONE), .RESULT(RESULT)
   );

   typedef struct {
      int          kind;   // 0 digit, 1 amount, 2 done
      int          cyc;
      logic [31:0] val;
      int          aux;    // transaction type for amount events
   } ev_t;

   ev_t sb[$];
   int  total;
   int  bad;
   int  cyc;
   bit  busy_chk;

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   initial begin
      cyc = 0;
      forever begin
         @(posedge CLK);
         cyc++;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic push_ev(input int kind, input int c, input logic [31:0] v, input int aux);
      ev_t e;
      e.kind = kind;
      e.cyc  = c;
      e.val  = v;
      e.aux  = aux;
      sb.push_back(e);
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_monto"}, MONTO, 32'd0);
      chk({tag, "_ctrl"}, 32'({TARJETA_RECIBIDA, TIPO_TRANS, DIGITO, DIGITO_STB,
                               MONTO_STB, BUSY, DONE, RESULT}), 32'd0);
   endtask

   // Monitor: pops one expected event per strobe seen on the DUT.
   initial begin
      busy_chk = 1'b0;
      forever begin
         @(negedge CLK);
         if (RESET === 1'b1) begin : mon_body
            int          k;
            logic [31:0] v;
            ev_t         e;
            if (busy_chk) begin
               chk("busy_after_done", 32'(BUSY), 32'd0);
               busy_chk = 1'b0;
            end
            if (DIGITO_STB || MONTO_STB || DONE) begin
               k = DONE ? 2 : (MONTO_STB ? 1 : 0);
               v = (k == 2) ? 32'(RESULT) : ((k == 1) ? MONTO : 32'(DIGITO));
               total++;
               if (sb.size() == 0) begin
                  bad++;
                  $display("FAIL unexpected_event: got kind %0d value %0h at cycle %0d, expected no event",
                           k, v, cyc);
               end else begin
                  e = sb.pop_front();
                  if (k != e.kind || v !== e.val || cyc != e.cyc) begin
                     bad++;
                     $display("FAIL event: got kind %0d value %0h cycle %0d, expected kind %0d value %0h cycle %0d",
                              k, v, cyc, e.kind, e.val, e.cyc);
                  end
                  if (k == 0) chk("tarjeta_at_digit", 32'(TARJETA_RECIBIDA), 32'd1);
                  if (k == 1) chk("tipo_at_amount", 32'(TIPO_TRANS), 32'(e.aux));
                  if (k == 2) begin
                     chk("tarjeta_at_done", 32'(TARJETA_RECIBIDA), 32'd0);
                     chk("busy_at_done", 32'(BUSY), 32'd1);
                     busy_chk = 1'b1;
                  end
               end
            end
         end
      end
   end

   // mode 0: PIN-phase flag at P+off, flg[1]=BLOQUEO flg[0]=PIN_INCORRECTO
   // mode 1: response at M+off, flg = {BLOQUEO, BALANCE, ENTREGAR, FONDOS}
   // mode 2: no response (timeout)
   // rst_at >= 0: reset asserted during the cycle visible at P+rst_at
   task automatic run_session(input bit trans, input logic [15:0] pin,
                              input logic [31:0] monto, input int mode,
                              input int off, input logic [3:0] flg,
                              input bit hold, input int rst_at);
      int c0, p, d0, m, a, done_c, code, n;
      @(negedge CLK);
      chk("idle_before_start", 32'(BUSY), 32'd0);
      c0 = cyc;
      p  = c0 + 1;
      d0 = p + CS;
      m  = d0 + 3 * (DG + 1) + PW + 1;
      a  = p + off;
      if (mode == 0) begin
         code   = flg[1] ? 5 : 4;
         done_c = a + 1;
      end else if (mode == 1) begin
         n = int'(flg[2]) + int'(flg[1]) + int'(flg[0]);
         if (flg[3])          code = 5;
         else if (n > 1)      code = 7;
         else if (trans == 0) code = flg[2] ? 1 : 7;
         else                 code = flg[1] ? 2 : (flg[0] ? 3 : 7);
         done_c = m + off + 1;
      end else begin
         code   = 6;
         done_c = m + RT;
      end
      for (int i = 0; i < 4; i++)
         if (mode != 0 || d0 + i * (DG + 1) <= a)
            push_ev(0, d0 + i * (DG + 1), 32'((pin >> (12 - 4 * i)) & 16'hF), 0);
      if (mode != 0) push_ev(1, m, monto, int'(trans));
      push_ev(2, done_c, 32'(code), 0);

      while (cyc <= done_c + 1) begin
         START    = (cyc == c0) || (hold && cyc <= done_c);
         TRANS_IN = (cyc == c0) ? trans : 1'($urandom);
         PIN_IN   = (cyc == c0) ? pin : 16'($urandom);
         MONTO_IN = (cyc == c0) ? monto : $urandom;
         BLOQUEO = 1'b0; PIN_INCORRECTO = 1'b0;
         BALANCE_ACTUALIZADO = 1'b0; ENTREGAR_DINERO = 1'b0; FONDOS_INSUFICIENTES = 1'b0;
         if (mode == 0 && cyc == a) begin
            BLOQUEO = flg[1]; PIN_INCORRECTO = flg[0];
         end
         if (mode == 1 && cyc == m + off) begin
            BLOQUEO = flg[3]; BALANCE_ACTUALIZADO = flg[2];
            ENTREGAR_DINERO = flg[1]; FONDOS_INSUFICIENTES = flg[0];
         end
         if (rst_at >= 0 && cyc == p + rst_at) begin
            START = 1'b0;
            #2 RESET = 1'b0;
            #1 check_all_zero("reset_abort");
            sb.delete();
            repeat (3) @(negedge CLK);
            RESET = 1'b1;
            return;
         end
         @(negedge CLK);
      end
      START = 1'b0;
      BLOQUEO = 1'b0; PIN_INCORRECTO = 1'b0;
      BALANCE_ACTUALIZADO = 1'b0; ENTREGAR_DINERO = 1'b0; FONDOS_INSUFICIENTES = 1'b0;
   endtask

   initial begin
      int pin_last;
      total = 0; bad = 0;
      RESET = 1'b0; START = 1'b0; TRANS_IN = 1'b0; PIN_IN = 16'd0; MONTO_IN = 32'd0;
      BALANCE_ACTUALIZADO = 1'b0; ENTREGAR_DINERO = 1'b0; FONDOS_INSUFICIENTES = 1'b0;
      PIN_INCORRECTO = 1'b0; BLOQUEO = 1'b0;
      repeat (2) @(negedge CLK);
      check_all_zero("reset_state");
      RESET = 1'b1;
      pin_last = CS + 3 * (DG + 1);

      run_session(1'b0, 16'h1234, 32'd500,        1, 5, 4'b0100, 1'b0, -1); // deposit ok
      run_session(1'b1, 16'h9876, 32'hFFFF_FFFF,  1, 4, 4'b0001, 1'b0, -1); // funds refused
      run_session(1'b1, 16'h9876, 32'hFFFF_FFFF,  1, 4, 4'b0010, 1'b0, -1); // cash dispensed
      run_session(1'b0, 16'h4321, 32'd77,         0, pin_last + 3, 4'b0001, 1'b0, -1);
      run_session(1'b1, 16'hABCD, 32'd10,         0, pin_last + 5, 4'b0011, 1'b0, -1);
      run_session(1'b1, 16'h0F0F, 32'd123,        2, 0, 4'b0000, 1'b0, -1);  // timeout
      run_session(1'b0, 16'h5555, 32'd9,          2, 0, 4'b0000, 1'b1, -1);  // START held
      run_session(1'b0, 16'h1111, 32'd1,          1, 2, 4'b0010, 1'b0, -1);  // mismatch
      run_session(1'b1, 16'h2222, 32'd2,          1, 3, 4'b0011, 1'b0, -1);  // two flags
      run_session(1'b0, 16'h3333, 32'd3,          1, 7, 4'b1100, 1'b0, -1);  // block wins
      run_session(1'b1, 16'h7777, 32'd4,          1, RT - 1, 4'b0010, 1'b0, -1);
      run_session(1'b1, 16'hC3A5, 32'd5,          0, CS + 1, 4'b0001, 1'b0, -1); // in 1st GAP
      run_session(1'b1, 16'h6789, 32'hDEAD_BEEF,  2, 0, 4'b0000, 1'b0, CS + 2 * (DG + 1) + 2);
      run_session(1'b0, 16'h1234, 32'd500,        1, 5, 4'b0100, 1'b0, -1);

      for (int s = 0; s < 25; s++) begin
         int md, of;
         logic [3:0] fl;
         md = int'($urandom_range(0, 2));
         if (md == 0) begin
            of = int'($urandom_range(CS, pin_last + PW));
            fl = 4'($urandom_range(1, 3));
         end else if (md == 1) begin
            of = int'($urandom_range(1, RT - 1));
            fl = 4'($urandom_range(1, 15));
         end else begin
            of = 0;
            fl = 4'd0;
         end
         run_session(1'($urandom), 16'($urandom), $urandom, md, of, fl,
                     1'($urandom), -1);
      end

      repeat (5) @(negedge CLK);
      chk("leftover_events", 32'(sb.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/atm_session_driver.md
Name: atm_session_driver

Overview:
- Customer-side initiator for the ATM controller (Cajero) interface; plays one complete transaction per request.
- Sequence: card insertion, 4-digit PIN as strobed nibbles, then amount with strobe.
- Classifies the controller's response into a result code for the upper-level test/host logic.
- Sits opposite the Cajero and replaces the hand-written stimulus block in system-level benches and the board front-end.

Parameters:
- CARD_SETUP, 2: idle cycles with TARJETA_RECIBIDA high before the first digit.
- DIGIT_GAP, 3: idle cycles between consecutive digit strobes.
- PIN_WAIT, 8: cycles after the last digit to watch for PIN_INCORRECTO/BLOQUEO.
- RESP_TIMEOUT, 32: maximum cycles after MONTO_STB to wait for a transaction outcome.

Ports:
- CLK input 1: system clock, rising edge.
- RESET input 1: asynchronous, active-low reset.
- START input 1: request a session; sampled only in IDLE.
- TRANS_IN input 1: transaction type, 0 = deposit, 1 = withdrawal; latched at START.
- PIN_IN input 16: four BCD digits, [15:12] sent first; latched at START.
- MONTO_IN input 32: amount; latched at START.
- TARJETA_RECIBIDA output 1: card present to Cajero.
- TIPO_TRANS output 1: latched transaction type.
- DIGITO output 4: current PIN digit.
- DIGITO_STB output 1: one-cycle digit-valid strobe.
- MONTO output 32: latched amount.
- MONTO_STB output 1: one-cycle amount-valid strobe.
- BALANCE_ACTUALIZADO input 1: deposit completed.
- ENTREGAR_DINERO input 1: cash dispensed.
- FONDOS_INSUFICIENTES input 1: withdrawal refused.
- PIN_INCORRECTO input 1: wrong PIN.
- BLOQUEO input 1: card blocked.
- BUSY output 1: session in progress.
- DONE output 1: one-cycle pulse when RESULT is valid.
- RESULT output 3: outcome code, held until the next START.

Behaviour:
- Reset (async, RESET=0): all outputs 0, RESULT=0, state IDLE, all latches and counters cleared. Reset mid-session aborts immediately with no DONE; TARJETA_RECIBIDA drops asynchronously.
- RESULT codes:
  - 0 = none
  - 1 = deposit OK
  - 2 = withdrawal OK
  - 3 = insufficient funds
  - 4 = PIN incorrect
  - 5 = blocked
  - 6 = timeout
  - 7 = unexpected response
- All outputs are registered. TIPO_TRANS, MONTO and TARJETA_RECIBIDA are stable for the whole session.
- States:
  - IDLE: BUSY=0. On START=1, latch inputs, clear RESULT, go to CARD. The cycle after START, TARJETA_RECIBIDA=1 and BUSY=1.
  - CARD: count CARD_SETUP cycles, then go to DIGIT with index 0.
  - DIGIT: one cycle with DIGITO_STB=1 and DIGITO=PIN nibble[index]. DIGITO holds its value until the next strobe. Index 0..3 maps to bits [15:12],[11:8],[7:4],[3:0].
    - Index < 3: go to GAP.
    - Index = 3: go to PWAIT.
  - GAP: count DIGIT_GAP cycles, then go to DIGIT with index+1.
  - PWAIT: count PIN_WAIT cycles.
    - BLOQUEO=1 → code 5, go to FINISH (BLOQUEO has priority).
    - PIN_INCORRECTO=1 → code 4, go to FINISH.
    - Count expires with neither → go to AMOUNT.
    - BLOQUEO or PIN_INCORRECTO sampled during DIGIT/GAP is also honoured, with the same priority.
  - AMOUNT: one cycle with MONTO_STB=1, then go to RWAIT.
  - RWAIT: count up to RESP_TIMEOUT.
    - Deposit: BALANCE_ACTUALIZADO → code 1.
    - Withdrawal: ENTREGAR_DINERO → code 2; FONDOS_INSUFICIENTES → code 3.
    - A response flag that does not match the transaction type, or two flags in the same cycle → code 7.
    - BLOQUEO → code 5.
    - Counter reaches RESP_TIMEOUT → code 6.
  - FINISH: TARJETA_RECIBIDA=0, DONE=1 for exactly one cycle, RESULT updated in the same cycle, BUSY=0 the next cycle, go to IDLE.
- START while BUSY is ignored. START in the same cycle as the FINISH→IDLE transition is ignored; START is accepted only in IDLE.
- Counters are sized for their parameter value and cannot wrap. Parameters ≥ 1.
- DIGITO values above 9 are sent unchanged; the block performs no validation.

Test Plan:
- Deposit OK: PIN_IN=16'h1234, TRANS_IN=0, MONTO_IN=500, responder asserts BALANCE_ACTUALIZADO 5 cycles after MONTO_STB → digits 1,2,3,4 strobed 4 cycles apart, MONTO_STB=1 with MONTO=500, DONE with RESULT=1, TARJETA_RECIBIDA falls at DONE.
- Withdrawal refused: TRANS_IN=1, MONTO_IN=32'hFFFF_FFFF, FONDOS_INSUFICIENTES pulsed → RESULT=3. Same setup with ENTREGAR_DINERO → RESULT=2.
- Wrong PIN: PIN_INCORRECTO pulsed 3 cycles after the 4th digit → RESULT=4, MONTO_STB never asserted.
- Block priority: BLOQUEO and PIN_INCORRECTO asserted in the same cycle during PWAIT → RESULT=5.
- Timeout: no response after MONTO_STB → DONE exactly RESP_TIMEOUT(32) cycles after the strobe, RESULT=6. Second test: START held high throughout → exactly one session.
- Reset abort: RESET driven low during the 3rd GAP → all outputs 0 immediately, no DONE. After release, a new START runs a full session normally.
